// File: rtl/seg_disp_pkg.sv
// Shared types and polarity helpers for the four-digit segment display path.
package seg_disp_pkg;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } scan_state_e;

  // Digit pattern layout: bit7 = decimal point, bits6..0 = segments g..a, 1 = lit.
  typedef struct packed {
    logic       dp;
    logic [6:0] gfedcba;
  } seg_pattern_t;

  function automatic logic [7:0] seg_off(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [3:0] an_off(input bit active_low);
    return active_low ? 4'hF : 4'h0;
  endfunction

  function automatic logic [7:0] seg_pol(input logic [7:0] lit, input bit active_low);
    return active_low ? ~lit : lit;
  endfunction

  function automatic logic [3:0] an_pol(input logic [3:0] on, input bit active_low);
    return active_low ? ~on : on;
  endfunction

endpackage

// File: rtl/seg_scan_driver_tick_gen.sv
// Per-slot cycle counter with strobes for end of blanking and end of slot.
module scan_tick_gen #(
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic blank_done,
  output logic slot_end
);

  localparam int unsigned CW         = $clog2(PRESCALE);
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign slot_end   = (cnt_q == CW'(PRESCALE - 1));
  assign blank_done = (BLANK_CYCLES != 0) && (cnt_q == CW'(BLANK_LAST));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed segment driver with per-frame double buffering and inter-digit blanking.
module seg_scan_driver
  import seg_disp_pkg::*;
#(
  parameter int unsigned PRESCALE       = 100000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       Clk100M,
  input  logic       resetN,
  input  logic       enable,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  input  logic [7:0] seg3,
  input  logic [3:0] blankMask,
  output logic [3:0] an,
  output logic [7:0] segOut,
  output logic       frameStart
);

  if (PRESCALE < 2 || PRESCALE > (1 << 20)) begin : g_bad_prescale
    $error("seg_scan_driver: PRESCALE out of range 2..2^20");
  end
  if (BLANK_CYCLES >= PRESCALE) begin : g_bad_blank
    $error("seg_scan_driver: BLANK_CYCLES must be < PRESCALE");
  end

  // With no blanking, every slot opens directly in DRIVE.
  localparam scan_state_e SLOT_FIRST = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  scan_state_e        state_q, state_d;
  digit_idx_t         idx_q, idx_d;
  seg_pattern_t [3:0] shadow_q, shadow_d;
  logic [3:0]         mask_q, mask_d;
  logic [3:0]         an_q, an_d;
  logic [7:0]         seg_q, seg_d;
  logic               fs_q, fs_d;
  logic               latch;
  logic               blank_done, slot_end;
  logic               tick_clear;

  assign tick_clear = (state_q == ST_IDLE) || !enable;

  scan_tick_gen #(
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_tick (
    .clk       (Clk100M),
    .rst_n     (resetN),
    .clear     (tick_clear),
    .run       (enable),
    .blank_done(blank_done),
    .slot_end  (slot_end)
  );

  always_ff @(posedge Clk100M or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    latch   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (enable) begin
          state_d = SLOT_FIRST;
          latch   = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (blank_done) begin
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (slot_end) begin
          state_d = SLOT_FIRST;
          idx_d   = idx_q + 2'd1;
          latch   = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    logic [3:0] an_act;
    logic [7:0] seg_act;
    an_act  = '0;
    seg_act = '0;
    if (state_q == ST_DRIVE) begin
      seg_act        = shadow_q[idx_q];
      an_act[idx_q]  = ~mask_q[idx_q];
    end
    an_d  = an_pol(an_act, AN_ACTIVE_LOW);
    seg_d = seg_pol(seg_act, SEG_ACTIVE_LOW);
    fs_d  = latch;
  end

  always_comb begin
    shadow_d = shadow_q;
    mask_d   = mask_q;
    if (latch) begin
      shadow_d = {seg3, seg2, seg1, seg0};
      mask_d   = blankMask;
    end
  end

  always_ff @(posedge Clk100M or negedge resetN) begin
    if (!resetN) begin
      idx_q    <= '0;
      shadow_q <= '0;
      mask_q   <= 4'hF;
      an_q     <= an_off(AN_ACTIVE_LOW);
      seg_q    <= seg_off(SEG_ACTIVE_LOW);
      fs_q     <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fs_q     <= fs_d;
    end
  end

  assign an         = an_q;
  assign segOut     = seg_q;
  assign frameStart = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame-position reference model plus literal timeline checks.
module tb_seg_scan_driver;

  localparam int PRE = 8;
  localparam int BLK = 2;
  localparam int FRAME = 4 * PRE;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] seg0 = '0, seg1 = '0, seg2 = '0, seg3 = '0;
  logic [3:0] blankMask = '0;
  logic [3:0] an;
  logic [7:0] segOut;
  logic       frameStart;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;
  int k = 0;

  // Reference model: whether a frame is running and the cycle position within it.
  bit         m_run = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_sh [4];
  logic [3:0] m_mask = 4'hF;

  seg_scan_driver #(
    .PRESCALE      (PRE),
    .BLANK_CYCLES  (BLK),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .Clk100M   (clk),
    .resetN    (resetN),
    .enable    (enable),
    .seg0      (seg0),
    .seg1      (seg1),
    .seg2      (seg2),
    .seg3      (seg3),
    .blankMask (blankMask),
    .an        (an),
    .segOut    (segOut),
    .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] ea;
    logic [7:0] es;
    logic       ef;
    logic [3:0] act;
    logic [7:0] lit;
    int slot, w;
    if (started) begin
      if (!resetN) begin
        m_run = 1'b0;
        m_pos = 0;
        for (int i = 0; i < 4; i++) m_sh[i] = 8'h00;
        m_mask = 4'hF;
        ea = 4'hF; es = 8'hFF; ef = 1'b0;
      end else begin
        act = '0;
        lit = '0;
        if (m_run) begin
          slot = m_pos / PRE;
          w    = m_pos % PRE;
          if (w >= BLK) begin
            lit = m_sh[slot];
            if (!m_mask[slot]) act = 4'b0001 << slot;
          end
        end
        ea = ~act;
        es = ~lit;
        ef = 1'b0;
        if (!enable) begin
          m_run = 1'b0;
        end else begin
          if (!m_run) begin
            m_run = 1'b1;
            m_pos = 0;
          end else begin
            m_pos = (m_pos + 1) % FRAME;
          end
          if (m_pos == 0) begin
            m_sh[0] = seg0; m_sh[1] = seg1; m_sh[2] = seg2; m_sh[3] = seg3;
            m_mask = blankMask;
            ef = 1'b1;
          end
        end
      end
      #1;
      chk("an", {28'd0, an}, {28'd0, ea});
      chk("segOut", {24'd0, segOut}, {24'd0, es});
      chk("frameStart", {31'd0, frameStart}, {31'd0, ef});
      chk("one_anode", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
    end
  end

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int t);
    while (k < t) step();
  endtask

  initial begin
    #2;
    resetN  = 1'b0;
    started = 1'b1;
    #1;
    chk("reset_an", {28'd0, an}, 32'hF);
    chk("reset_seg", {24'd0, segOut}, 32'hFF);
    chk("reset_fs", {31'd0, frameStart}, 32'd0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    seg0 = 8'h3F; seg1 = 8'h06; seg2 = 8'h5B; seg3 = 8'h4F;
    blankMask = 4'h0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    k = -1;

    step();
    chk("lit_fs_first", {31'd0, frameStart}, 32'd1);
    chk("lit_an_k0", {28'd0, an}, 32'hF);
    step();
    chk("lit_fs_k1", {31'd0, frameStart}, 32'd0);
    chk("lit_an_k1", {28'd0, an}, 32'hF);
    run_to(3);
    chk("lit_an_d0", {28'd0, an}, 32'hE);
    chk("lit_seg_d0", {24'd0, segOut}, 32'hC0);
    run_to(10);
    seg2 = 8'hFF;
    run_to(11);
    chk("lit_an_d1", {28'd0, an}, 32'hD);
    chk("lit_seg_d1", {24'd0, segOut}, 32'hF9);
    run_to(19);
    chk("lit_an_d2_f1", {28'd0, an}, 32'hB);
    chk("lit_seg_d2_f1", {24'd0, segOut}, 32'hA4);
    run_to(32);
    chk("lit_fs_second", {31'd0, frameStart}, 32'd1);
    run_to(51);
    chk("lit_an_d2_f2", {28'd0, an}, 32'hB);
    chk("lit_seg_d2_f2", {24'd0, segOut}, 32'h00);
    run_to(60);
    blankMask = 4'b0100;
    run_to(83);
    chk("lit_an_masked", {28'd0, an}, 32'hF);
    run_to(91);
    chk("lit_an_d3", {28'd0, an}, 32'h7);
    chk("lit_seg_d3", {24'd0, segOut}, 32'hB0);
    run_to(96);
    chk("lit_fs_third", {31'd0, frameStart}, 32'd1);
    run_to(107);
    chk("lit_an_d1_pre_off", {28'd0, an}, 32'hD);
    enable = 1'b0;
    run_to(109);
    chk("lit_an_off", {28'd0, an}, 32'hF);
    chk("lit_seg_off", {24'd0, segOut}, 32'hFF);
    run_to(112);
    enable = 1'b1;
    blankMask = 4'h0;
    step();
    chk("lit_fs_reenable", {31'd0, frameStart}, 32'd1);
    run_to(116);
    chk("lit_an_restart", {28'd0, an}, 32'hE);
    chk("lit_seg_restart", {24'd0, segOut}, 32'hC0);
    run_to(118);
    resetN = 1'b0;
    #1;
    chk("lit_async_an", {28'd0, an}, 32'hF);
    chk("lit_async_seg", {24'd0, segOut}, 32'hFF);
    chk("lit_async_fs", {31'd0, frameStart}, 32'd0);
    step();
    step();
    resetN = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      step();
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 3) == 0) begin
        seg0 = 8'($urandom); seg1 = 8'($urandom);
        seg2 = 8'($urandom); seg3 = 8'($urandom);
        blankMask = 4'($urandom);
      end
    end
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
